// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types and constants for the seven-segment display blocks.
//   state_t   - slot phase: BLANK (all anodes off) or SHOW (digit lit)
//   HEX_GLYPH - 16-entry hex glyph table, {g,f,e,d,c,b,a}, active low
//   SEG_OFF   - all segments dark
//   AN_OFF    - all anodes disabled
package sseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Index is the nibble value; entry is the active-low segment pattern.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/sseg_hex_decode.sv
// sseg_hex_decode: combinational 4-bit to 7-segment glyph lookup.
//   nibble - hex digit to render
//   glyph  - segments {g,f,e,d,c,b,a}, active low
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Pure table lookup so every display block renders digits identically.
  assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed scan controller for a 4-digit common-anode
// seven-segment display showing a 16-bit value as hex.
//   clk        - system clock
//   rst        - synchronous active-high reset
//   val        - value to display, val[3:0] is the rightmost digit
//   load       - one-cycle strobe capturing val into the pending register
//   dp_mask    - decimal point enables per digit (1 = lit), sampled live
//   lz_blank   - enables leading-zero suppression, sampled live
//   an         - anode enables, active low, an[0] = rightmost digit
//   seg        - segments {g,f,e,d,c,b,a}, active low
//   dp         - decimal point, active low
//   frame_done - one-cycle pulse in the last cycle of each 4-digit frame
module sseg_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] val,
  input  logic        load,
  input  logic [3:0]  dp_mask,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  import sseg_pkg::*;

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  state_t        state_q, state_d;
  logic [15:0]   pending_q, pending_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          at_wrap;
  logic          at_frame_end;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic          suppress;

  sseg_hex_decode u_decode (
    .nibble (nibble),
    .glyph  (glyph)
  );

  // Slot counter, digit rotation and the tear-free value handoff. The shadow
  // only changes on the frame boundary; taking pending_d there means a load
  // landing exactly on the boundary goes straight to the display. frame_done
  // is predicted from the next state so its pulse coincides with the boundary.
  always_comb begin
    at_wrap      = (cnt_q == CNT_LAST);
    at_frame_end = at_wrap && (digit_q == 2'd3);
    cnt_d        = at_wrap ? '0 : cnt_q + CW'(1);
    digit_d      = at_wrap ? digit_q + 2'd1 : digit_q;
    state_d      = (cnt_d < CNT_BLANK) ? sseg_pkg::BLANK : sseg_pkg::SHOW;
    pending_d    = load ? val : pending_q;
    shadow_d     = at_frame_end ? pending_d : shadow_q;
    frame_done_d = (cnt_d == CNT_LAST) && (digit_d == 2'd3);
  end

  // Pick the current digit's nibble and decide leading-zero suppression:
  // digit i >= 1 goes dark when every nibble from 3 down to i is zero.
  always_comb begin
    nibble   = shadow_q[{digit_q, 2'b00} +: 4];
    suppress = lz_blank && (digit_q != 2'd0) &&
               ((shadow_q >> {digit_q, 2'b00}) == 16'd0);
  end

  // Pin drive for the next cycle. Everything is dark in the blanking gap;
  // a suppressed digit keeps its anode off but still shows its decimal point.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_q == sseg_pkg::SHOW) begin
      dp_d = ~dp_mask[digit_q];
      if (!suppress) begin
        an_d  = ~(4'b0001 << digit_q);
        seg_d = glyph;
      end
    end
  end

  // All state and registered outputs; reset wins over any load in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      digit_q      <= 2'd0;
      state_q      <= sseg_pkg::BLANK;
      pending_q    <= 16'd0;
      shadow_q     <= 16'd0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      state_q      <= state_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: self-checking bench for sseg_scan_ctrl with DIV=8,
// BLANK=2. A behavioural model tracks the cycle position since reset and
// the pending/displayed values, and predicts the pins each cycle.
module tb_sseg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] val = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  dp_mask = 4'h0;
  logic        lz_blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: position in the scan since reset, plus the two value regs.
  int          pos = 0;
  logic [15:0] m_pending = 16'h0;
  logic [15:0] m_shadow  = 16'h0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fd;
  logic [3:0]  cur_dp = 4'h0;
  logic        cur_lz = 1'b0;

  logic [6:0] glyph_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [3:0] an_hist [41];
  logic [6:0] seg_hist [41];
  logic       fd_hist [41];

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .val        (val),
    .load       (load),
    .dp_mask    (dp_mask),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    n_checks++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %h, expected %h (pos %0d)", tag, got, exp, pos);
    else
      n_pass++;
  endtask

  // Drive one cycle of inputs, predict the pins that the next edge produces,
  // advance the model, then compare just after the edge.
  task automatic applyStimulus(input logic r, input logic ld,
                               input logic [15:0] v, input logic [3:0] dpm,
                               input logic lz);
    int          ph;
    int          d;
    logic [15:0] upper;
    rst      = r;
    load     = ld;
    val      = v;
    dp_mask  = dpm;
    lz_blank = lz;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_fd  = 1'b0;
    if (r) begin
      pos       = 0;
      m_pending = 16'h0;
      m_shadow  = 16'h0;
    end else begin
      ph    = pos % DIV;
      d     = (pos / DIV) % 4;
      upper = m_shadow >> (4 * d);
      if (ph >= BLANK) begin
        e_dp = ~dpm[d];
        if (!(lz && d > 0 && upper == 16'h0)) begin
          e_an  = ~(4'b0001 << d);
          e_seg = glyph_ref[upper[3:0]];
        end
      end
      e_fd = (((pos + 1) % FRAME) == FRAME - 1);
      if (ld) m_pending = v;
      if ((pos % FRAME) == FRAME - 1) m_shadow = m_pending;
      pos++;
    end
    @(posedge clk);
    #1;
    checkOutput("an", {12'h0, an}, {12'h0, e_an});
    checkOutput("seg", {9'h0, seg}, {9'h0, e_seg});
    checkOutput("dp", {15'h0, dp}, {15'h0, e_dp});
    checkOutput("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 16'h0, cur_dp, cur_lz);
  endtask

  initial begin
    logic [15:0] rv;

    // Reset and free-running scan with a zero value.
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 4'h0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      idle(1);
      an_hist[k]  = an;
      seg_hist[k] = seg;
      fd_hist[k]  = frame_done;
    end
    checkOutput("scan_an_c2", {12'h0, an_hist[2]}, 16'h000F);
    checkOutput("scan_an_c3", {12'h0, an_hist[3]}, 16'h000E);
    checkOutput("scan_an_c8", {12'h0, an_hist[8]}, 16'h000E);
    checkOutput("scan_an_c9", {12'h0, an_hist[9]}, 16'h000F);
    checkOutput("scan_an_c11", {12'h0, an_hist[11]}, 16'h000D);
    checkOutput("scan_an_c16", {12'h0, an_hist[16]}, 16'h000D);
    checkOutput("scan_seg_c3", {9'h0, seg_hist[3]}, 16'h0040);
    checkOutput("scan_fd_c30", {15'h0, fd_hist[30]}, 16'h0000);
    checkOutput("scan_fd_c31", {15'h0, fd_hist[31]}, 16'h0001);

    // Mid-frame load must not tear the frame in progress.
    applyStimulus(1'b0, 1'b1, 16'h1A8F, cur_dp, cur_lz);
    idle(60);

    // Load landing on the frame boundary shows in the very next digit-0 slot.
    while ((pos % FRAME) != FRAME - 1) idle(1);
    applyStimulus(1'b0, 1'b1, 16'h0008, cur_dp, cur_lz);
    idle(3);
    checkOutput("boundary_seg", {9'h0, seg}, 16'h0000);
    idle(32);

    // Leading-zero blanking, then an all-zero value.
    cur_lz = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0010, cur_dp, cur_lz);
    idle(70);
    applyStimulus(1'b0, 1'b1, 16'h0000, cur_dp, cur_lz);
    idle(70);

    // Decimal point on digit 2 only.
    cur_lz = 1'b0;
    cur_dp = 4'b0100;
    applyStimulus(1'b0, 1'b1, 16'h4321, cur_dp, cur_lz);
    idle(70);

    // Reset during the SHOW phase of digit 2 abandons the frame and pending.
    applyStimulus(1'b0, 1'b1, 16'h9999, cur_dp, cur_lz);
    while ((pos % FRAME) != 2 * DIV + 4) idle(1);
    applyStimulus(1'b1, 1'b0, 16'h0, cur_dp, cur_lz);
    checkOutput("midrst_an", {12'h0, an}, 16'h000F);
    checkOutput("midrst_seg", {9'h0, seg}, 16'h007F);
    idle(40);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 900; i++) begin
      case ($urandom_range(0, 2))
        0:       rv = 16'($urandom);
        1:       rv = 16'($urandom_range(0, 255));
        default: rv = 16'h0;
      endcase
      if ($urandom_range(0, 49) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(0, 19) == 0) cur_dp = 4'($urandom);
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
                    rv, cur_dp, cur_lz);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Time-multiplexing scan controller for the board's 4-digit common-anode seven-segment display. It sits between user logic and the `an`/`seg`/`dp` pins and displays a 16-bit value as four hex digits. It rotates through the digit anodes at a programmable rate with a blanking gap between digits, which prevents ghosting. The displayed value changes only at frame boundaries, so the display never shows a mix of old and new digits.

## Interface
Parameters:
- `DIV`, 100000: clock cycles per digit slot (1 ms at 100 MHz). Must be greater than `BLANK`.
- `BLANK`, 1000: cycles at the start of each slot during which all anodes are off. Must be at least 1.

Ports:
- `clk`  in  1  system clock. This is the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `val`  in  16  value to display. `val[3:0]` is the rightmost digit (digit 0).
- `load`  in  1  one-cycle strobe that captures `val` into the pending register.
- `dp_mask`  in  4  decimal point enables, one bit per digit. 1 = lit.
- `lz_blank`  in  1  1 enables leading-zero blanking.
- `an`  out  4  anode enables, active low. `an[0]` is the rightmost digit.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active low. `seg[0]` is segment a.
- `dp`  out  1  decimal point, active low.
- `frame_done`  out  1  one-cycle pulse at the end of each 4-digit frame.

## Operation
- **Registers:** `pending[15:0]`, `shadow[15:0]` (the value being displayed), `digit[1:0]`, slot counter `cnt` of width $clog2(DIV), and `state` ∈ {BLANK, SHOW}.
- **Slot FSM:**
  - `cnt` counts from 0 to DIV-1 and then wraps to 0.
  - `state` is BLANK while `cnt` < BLANK and SHOW otherwise.
  - On wrap, `digit` increments modulo 4.
- **Frame boundary:** the cycle where `cnt`=DIV-1 and `digit`=3. In that cycle:
  - `frame_done` is set for one cycle.
  - `shadow` loads from `pending`.
  - If `load` is asserted in the same cycle, `shadow` and `pending` both take `val` directly, so the new value wins.
- **Load:** `load` in any other cycle writes `pending` <= `val`. Multiple loads within one frame keep only the last one.
- **Decode:** nibble = `shadow[4*digit +: 4]`, mapped to the hex glyph. Reference glyphs:
  - 0 → 1000000
  - 1 → 1111001
  - 8 → 0000000
  - A → 0001000
  - F → 0001110
- **Leading-zero blanking:** digit i (i ≥ 1) is suppressed when `lz_blank`=1 and every nibble from 3 down to i is zero. Digit 0 is never suppressed.
  - A suppressed digit drives `seg`=1111111 and keeps its anode high (off).
  - `dp` still follows `dp_mask` on a suppressed digit.
- **Outputs during BLANK:** `an`=1111, `seg`=1111111, `dp`=1.
- **Outputs during SHOW (digit not suppressed):** `an` = ~(1 << `digit`), `seg` = glyph, `dp` = ~`dp_mask[digit]`.
- **Live inputs:** `dp_mask` and `lz_blank` are sampled live and are not shadowed.

## Timing
- **Reset values:**
  - `an`=1111, `seg`=1111111, `dp`=1, `frame_done`=0.
  - `cnt`=0, `digit`=0, `state`=BLANK.
  - `pending`=0, `shadow`=0.
- **Output latency:** all outputs are registered, one cycle after the `cnt`/`digit` state that produces them.
- **First anode after reset:** the first cycle after `rst` deasserts is counted as `cnt`=0. `an[0]` first goes low on cycle BLANK+1.
- **Frame timing:**
  - Frame length is 4·DIV cycles.
  - `frame_done` is high for exactly 1 cycle per frame.
  - `shadow` reflects the new value starting with the digit-0 slot that follows.
- **Load to display:** a value loaded at cycle t appears on the display no later than the next frame boundary, plus BLANK+1 cycles.
- **Mid-operation reset:** `rst` asserted at any time forces the reset values on the next edge. A partial slot or frame is abandoned and `pending` is lost.
- **Reset priority:** `rst` has priority over `load`.

## Structure
- **Package `sseg_pkg`:**
  - `state_t` enum {BLANK, SHOW}
  - the 16-entry `HEX_GLYPH` constant array, 7-bit active low
  - `SEG_OFF` = 7'h7F
  - `AN_OFF` = 4'hF
- **Sub-module `sseg_hex_decode`:** a combinational 4-bit → 7-bit glyph lookup driven from `HEX_GLYPH`. It is reused by other display blocks.
- **Top level:** the counter, FSM, shadow logic and blanking logic live in `sseg_scan_ctrl`.

## Test plan
All scenarios use DIV=8 and BLANK=2.
- **Reset/scan:** release `rst` with `val` untouched → `an`=1111 for cycles 1–2, then `an`=1110 for 6 cycles, then 1111 for 2 cycles and 1101 for 6 cycles. `seg`=1000000 while lit. `frame_done` pulses once every 32 cycles.
- **Tear-free load:** `load` with `val`=16'h1A8F at mid-frame → the rest of the current frame still shows 0000. The next frame shows digit0 0001110, digit1 0000000, digit2 0001000, digit3 1111001.
- **Load at boundary:** `load` coincident with `frame_done` and `val`=16'h0008 → the very next digit-0 slot shows 0000000.
- **Leading-zero blanking:** `val`=16'h0010, `lz_blank`=1 → digits 3 and 2 keep `an` high, digit 1 shows 1111001, digit 0 shows 1000000. With `val`=0, only digit 0 lights.
- **Decimal point:** `dp_mask`=4'b0100 → `dp`=0 only during the SHOW phase of digit 2. `dp`=1 during every BLANK phase.
- **Mid-frame reset:** assert `rst` during the SHOW phase of digit 2 → outputs return to reset values on the next edge, and the scan restarts at digit 0 with `shadow`=0.
